rv_fetch_queue: RTL

Parametrised instruction-fetch front end for the RV32I pipeline. It replaces the fixed single-request, 1-cycle-latency fetch with a pipelined fetch unit:
- up to MAX_OUT instruction-memory requests in flight, with variable response latency;
- responses stored in a FQ_DEPTH-entry instruction queue with their PCs;
- a valid/ready interface to decode;
- redirect (branch/jump flush) support that discards stale in-flight responses.

The block sits between imem and the ID stage.

---
 rtl/rv_fetch_queue.sv | 89 ++++++++
 1 files changed

// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue: pipelined RV32I fetch front end with in-flight request tracking,
// an instruction queue toward decode, and redirect flush of stale responses.
module rv_fetch_queue #(
   parameter int XLEN = 32,
   parameter int IADDR_W = 16,
   parameter int FQ_DEPTH = 4,
   parameter int MAX_OUT = 2,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic [IADDR_W-1:0]         imem_addr,
   output logic                       imem_oe,
   input  logic [31:0]                imem_rdata,
   input  logic                       imem_ready,
   input  logic                       redirect,
   input  logic [XLEN-1:0]            redirect_pc,
   output logic                       inst_valid,
   output logic [31:0]                inst,
   output logic [XLEN-1:0]            inst_pc,
   input  logic                       inst_ready,
   output logic [$clog2(FQ_DEPTH):0]  fq_count
);
   localparam int PW = $clog2(FQ_DEPTH);
   localparam int CW = PW + 1;
   localparam int OW = $clog2(MAX_OUT + 1);
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     ins;
   } entry_t;
   logic [XLEN-1:0] pc_f_q, pc_f_d, pc_r_q, pc_r_d;
   logic [OW-1:0]   out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d;
   logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   entry_t          mem_q [FQ_DEPTH];
   entry_t          mem_d [FQ_DEPTH];
   logic            resp, push, pop;
   always_comb begin
      // Every in-flight request owns a queue slot, so a push can never find the queue full.
      imem_oe = !rst && !redirect && (int'(out_cnt_q) < MAX_OUT)
                && (int'(count_q) + int'(out_cnt_q) < FQ_DEPTH);
      imem_addr = pc_f_q[IADDR_W-1:0];
      resp = imem_ready && out_cnt_q != '0;
      inst_valid = count_q != '0 && !redirect;
      pop = inst_valid && inst_ready;
      push = resp && drop_cnt_q == '0 && !redirect;
      inst = inst_valid ? mem_q[head_q].ins : 32'h0000_0013;
      inst_pc = inst_valid ? mem_q[head_q].pc : '0;
      fq_count = count_q;
      out_cnt_d = out_cnt_q + OW'(imem_oe) - OW'(resp);
      drop_cnt_d = drop_cnt_q - OW'(resp && drop_cnt_q != '0);
      pc_f_d = imem_oe ? pc_f_q + XLEN'(4) : pc_f_q;
      pc_r_d = push ? pc_r_q + XLEN'(4) : pc_r_q;
      head_d = pop ? head_q + PW'(1) : head_q;
      tail_d = push ? tail_q + PW'(1) : tail_q;
      count_d = count_q + CW'(push) - CW'(pop);
      mem_d = mem_q;
      if (push) mem_d[tail_q] = {pc_r_q, imem_rdata};
      // Everything still outstanding after this cycle belongs to the old stream.
      if (redirect) begin
         pc_f_d = redirect_pc & ~XLEN'(3);
         pc_r_d = redirect_pc & ~XLEN'(3);
         drop_cnt_d = out_cnt_q - OW'(resp);
         head_d = tail_q;
         count_d = '0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_f_q <= RESET_PC;
         pc_r_q <= RESET_PC;
         out_cnt_q <= '0;
         drop_cnt_q <= '0;
         head_q <= '0;
         tail_q <= '0;
         count_q <= '0;
         mem_q <= '{default: '0};
      end else begin
         pc_f_q <= pc_f_d;
         pc_r_q <= pc_r_d;
         out_cnt_q <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         head_q <= head_d;
         tail_q <= tail_d;
         count_q <= count_d;
         mem_q <= mem_d;
      end
   end
endmodule
